// File: rtl/digit_streamer_gen.sv
// digit_streamer_gen: streams a latched BCD number as glyph bytes to an OLED driver, then issues a sync
// Ports:
//   clk_in, reset_n_in            clock, asynchronous active-low reset
//   digits, dp_pos, write_stb     value to display, decimal-point digit (DIGITS_NUM = none), write request
//   ready, busy                   write accepted this cycle, frame in progress
//   glyph_digit/dp/x/y            request to the external combinational glyph lookup
//   glyph_pixels                  lookup result, same cycle
//   oled_data, oled_write_stb     byte and data strobe to the driver
//   oled_sync_stb, oled_ready     end-of-frame strobe, driver ready
// Optional: define DIGIT_STREAMER_BLANK_EN for leading-zero blanking.
module digit_streamer_gen #(
  parameter int DIGITS_NUM = 6,
  parameter int GLYPH_W = 21,
  parameter int GLYPH_PAGES = 4,
  parameter int GAP_COLS = 0,
  parameter int MSD_FIRST = 0,
  localparam int DPW = $clog2(DIGITS_NUM + 1),
  localparam int GXW = $clog2(GLYPH_W),
  localparam int GYW = $clog2(GLYPH_PAGES)
) (
  input  logic                    clk_in,
  input  logic                    reset_n_in,
  input  logic [4*DIGITS_NUM-1:0] digits,
  input  logic [DPW-1:0]          dp_pos,
  input  logic                    write_stb,
  output logic                    ready,
  output logic                    busy,
  output logic [3:0]              glyph_digit,
  output logic                    glyph_dp,
  output logic [GXW-1:0]          glyph_x,
  output logic [GYW-1:0]          glyph_y,
  input  logic [7:0]              glyph_pixels,
  output logic [7:0]              oled_data,
  output logic                    oled_write_stb,
  output logic                    oled_sync_stb,
  input  logic                    oled_ready
);
  localparam int XTOT = GLYPH_W + GAP_COLS;
  localparam int XW = $clog2(XTOT + 1);
  localparam int YW = $clog2(GLYPH_PAGES + 1);
  localparam logic [XW-1:0] X_GLYPH_LAST = XW'(GLYPH_W - 1);
  localparam logic [XW-1:0] X_GAP_LAST = XW'(XTOT - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(GLYPH_PAGES - 1);
  localparam logic [DPW-1:0] S_LAST = DPW'(DIGITS_NUM - 1);
  localparam logic [DPW-1:0] DP_NONE = DPW'(DIGITS_NUM);
  typedef enum logic [2:0] {IDLE, SEND_DATA, WAIT_READY, SEND_SYNC, WAIT_SYNC} state_t;
  state_t state_q, state_d;
  logic [YW-1:0] y_q, y_d;
  logic [XW-1:0] x_q, x_d;
  logic [DPW-1:0] s_q, s_d;
  logic [4*DIGITS_NUM-1:0] dig_q, dig_d, pdig_q, pdig_d, src_dig;
  logic [DPW-1:0] dp_q, dp_d, pdp_q, pdp_d, src_dp;
  logic [DIGITS_NUM-1:0] blank_q, blank_d, new_blank;
  logic pv_q, pv_d;
  logic [DPW-1:0] idx;
  logic gap, blank_cur, y_wrap, x_wrap, last_byte;
`ifdef DIGIT_STREAMER_BLANK_EN
  // A digit is blanked when it and everything above it is zero, it is not digit 0,
  // and it sits above the decimal point (if one is shown).
  function automatic logic [DIGITS_NUM-1:0] blank_of(input logic [4*DIGITS_NUM-1:0] dg, input logic [DPW-1:0] dp);
    logic [DIGITS_NUM-1:0] b;
    logic zero_above;
    b = '0;
    zero_above = 1'b1;
    for (int d = DIGITS_NUM - 1; d > 0; d--) begin
      zero_above = zero_above && (dg[4*d +: 4] == 4'd0);
      b[d] = zero_above && (dp >= DP_NONE || DPW'(d) > dp);
    end
    return b;
  endfunction
`endif
  assign idx = (MSD_FIRST != 0) ? S_LAST - s_q : s_q;
  assign gap = x_q > X_GLYPH_LAST;
  assign blank_cur = blank_q[idx];
  assign glyph_digit = 4'(dig_q >> (4 * idx));
  assign glyph_dp = (dp_q == idx) && !blank_cur;
  assign glyph_x = gap ? GXW'(GLYPH_W - 1) : x_q[GXW-1:0];
  assign glyph_y = y_q[GYW-1:0];
  assign oled_data = (gap || blank_cur) ? 8'h00 : glyph_pixels;
  assign oled_write_stb = state_q == SEND_DATA;
  assign oled_sync_stb = state_q == SEND_SYNC;
  assign busy = state_q != IDLE;
  assign ready = !pv_q;
  // Page is the inner loop, then column (gap columns only between slots), then slot.
  assign y_wrap = y_q == Y_LAST;
  assign x_wrap = x_q == ((s_q == S_LAST) ? X_GLYPH_LAST : X_GAP_LAST);
  assign last_byte = y_wrap && x_wrap && s_q == S_LAST;
  assign src_dig = pv_q ? pdig_q : digits;
  assign src_dp = pv_q ? pdp_q : dp_pos;
`ifdef DIGIT_STREAMER_BLANK_EN
  assign new_blank = blank_of(src_dig, src_dp);
`else
  assign new_blank = '0;
`endif
  always_comb begin
    state_d = state_q;
    y_d = y_q;
    x_d = x_q;
    s_d = s_q;
    dig_d = dig_q;
    dp_d = dp_q;
    blank_d = blank_q;
    pv_d = pv_q;
    pdig_d = pdig_q;
    pdp_d = pdp_q;
    case (state_q)
      // A pending value wins over a fresh write; the fresh write is not accepted while ready is low.
      IDLE: if (pv_q || write_stb) begin
        state_d = SEND_DATA;
        dig_d = src_dig;
        dp_d = src_dp;
        blank_d = new_blank;
        y_d = '0;
        x_d = '0;
        s_d = '0;
        pv_d = 1'b0;
      end
      SEND_DATA: state_d = oled_ready ? SEND_DATA : WAIT_READY;
      WAIT_READY: if (oled_ready) begin
        state_d = last_byte ? SEND_SYNC : SEND_DATA;
        y_d = y_wrap ? '0 : y_q + 1'b1;
        x_d = !y_wrap ? x_q : x_wrap ? '0 : x_q + 1'b1;
        s_d = (y_wrap && x_wrap) ? s_q + 1'b1 : s_q;
      end
      SEND_SYNC: state_d = oled_ready ? SEND_SYNC : WAIT_SYNC;
      WAIT_SYNC: state_d = oled_ready ? IDLE : WAIT_SYNC;
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && write_stb && !pv_q) begin
      pv_d = 1'b1;
      pdig_d = digits;
      pdp_d = dp_pos;
    end
  end
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q <= IDLE;
      y_q <= '0;
      x_q <= '0;
      s_q <= '0;
      dig_q <= '0;
      dp_q <= DP_NONE;
      blank_q <= '0;
      pv_q <= 1'b0;
      pdig_q <= '0;
      pdp_q <= DP_NONE;
    end else begin
      state_q <= state_d;
      y_q <= y_d;
      x_q <= x_d;
      s_q <= s_d;
      dig_q <= dig_d;
      dp_q <= dp_d;
      blank_q <= blank_d;
      pv_q <= pv_d;
      pdig_q <= pdig_d;
      pdp_q <= pdp_d;
    end
  end
endmodule

// File: tb/tb_digit_streamer_gen.sv
// tb_digit_streamer_gen: checks digit_streamer_gen frames against a scan-order reference model
module tb_digit_streamer_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [23:0] a_dig = '0;
  logic [2:0] a_dp = 3'd6;
  logic a_wr = 1'b0;
  logic a_ready, a_busy, a_gdp, a_stb, a_sync, a_rdy;
  logic [3:0] a_gd;
  logic [4:0] a_gx;
  logic [1:0] a_gy;
  logic [7:0] a_pix, a_data;

  logic [11:0] b_dig = '0;
  logic [1:0] b_dp = 2'd3;
  logic b_wr = 1'b0;
  logic b_ready, b_busy, b_gdp, b_stb, b_sync, b_rdy;
  logic [3:0] b_gd;
  logic [4:0] b_gx;
  logic [1:0] b_gy;
  logic [7:0] b_data;

  int checks = 0;
  int passes = 0;
  int a_syncs = 0;
  int b_syncs = 0;
  int a_cnt, b_cnt;
  int hold_lo = 2;
  int hold_hi = 2;
  logic [28:0] obs_a[$];
  logic [28:0] obs_b[$];
  logic [28:0] exp_q[$];

  function automatic logic [7:0] pix(input logic [3:0] dg, input logic dp, input int x, input int y);
    return 8'((int'(dg) << 4) ^ (x * 7) ^ (y << 1) ^ (int'(dp) << 7)) | 8'h01;
  endfunction

  assign a_pix = pix(a_gd, a_gdp, int'(a_gx), int'(a_gy));

  digit_streamer_gen dut_a (
    .clk_in(clk), .reset_n_in(rst_n), .digits(a_dig), .dp_pos(a_dp), .write_stb(a_wr),
    .ready(a_ready), .busy(a_busy), .glyph_digit(a_gd), .glyph_dp(a_gdp), .glyph_x(a_gx),
    .glyph_y(a_gy), .glyph_pixels(a_pix), .oled_data(a_data), .oled_write_stb(a_stb),
    .oled_sync_stb(a_sync), .oled_ready(a_rdy)
  );

  digit_streamer_gen #(.DIGITS_NUM(3), .GAP_COLS(2), .MSD_FIRST(1)) dut_b (
    .clk_in(clk), .reset_n_in(rst_n), .digits(b_dig), .dp_pos(b_dp), .write_stb(b_wr),
    .ready(b_ready), .busy(b_busy), .glyph_digit(b_gd), .glyph_dp(b_gdp), .glyph_x(b_gx),
    .glyph_y(b_gy), .glyph_pixels(8'hFF), .oled_data(b_data), .oled_write_stb(b_stb),
    .oled_sync_stb(b_sync), .oled_ready(b_rdy)
  );

  // Driver models: drop ready one cycle after a strobe, raise it after a hold of hold_lo..hold_hi cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rdy <= 1'b1;
      a_cnt <= 0;
    end else if ((a_stb || a_sync) && a_rdy) begin
      a_rdy <= 1'b0;
      a_cnt <= int'($urandom_range(hold_hi, hold_lo));
    end else if (!a_rdy) begin
      if (a_cnt <= 1) a_rdy <= 1'b1;
      a_cnt <= a_cnt - 1;
    end
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_rdy <= 1'b1;
      b_cnt <= 0;
    end else if ((b_stb || b_sync) && b_rdy) begin
      b_rdy <= 1'b0;
      b_cnt <= int'($urandom_range(hold_hi, hold_lo));
    end else if (!b_rdy) begin
      if (b_cnt <= 1) b_rdy <= 1'b1;
      b_cnt <= b_cnt - 1;
    end
  end

  // Each byte the driver accepts is logged as {dp, digit, x, y, data}.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_stb && a_rdy) obs_a.push_back({a_gdp, a_gd, 8'(a_gx), 8'(a_gy), a_data});
      if (a_sync && a_rdy) a_syncs++;
      if (b_stb && b_rdy) obs_b.push_back({b_gdp, b_gd, 8'(b_gx), 8'(b_gy), b_data});
      if (b_sync && b_rdy) b_syncs++;
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Reference frame: instance 0 is 6 digits LSD-first no gap; instance 1 is 3 digits MSD-first, 2 gap cols, pixels FF.
  task automatic build(input int inst, input logic [23:0] dg, input int dp);
    int nd, gp;
    nd = inst == 0 ? 6 : 3;
    gp = inst == 0 ? 0 : 2;
    exp_q.delete();
    for (int s = 0; s < nd; s++)
      for (int x = 0; x < 21 + ((s < nd - 1) ? gp : 0); x++)
        for (int y = 0; y < 4; y++) begin
          int d, gx;
          logic [3:0] v;
          logic bl, dpf;
          logic [7:0] data;
          d = (inst == 0) ? s : nd - 1 - s;
          v = 4'(dg >> (4 * d));
`ifdef DIGIT_STREAMER_BLANK_EN
          bl = d != 0 && (dg >> (4 * d)) == 0 && (dp >= nd || d > dp);
`else
          bl = 1'b0;
`endif
          dpf = (dp == d) && !bl;
          gx = (x < 21) ? x : 20;
          data = (x >= 21 || bl) ? 8'h00 : (inst == 0 ? pix(v, dpf, gx, y) : 8'hFF);
          exp_q.push_back({dpf, v, 8'(gx), 8'(y), data});
        end
  endtask

  task automatic check_frame(input string nm, input int inst, input int start, input logic [23:0] dg, input int dp);
    int bad, n;
    logic [28:0] act;
    build(inst, dg, dp);
    bad = -1;
    act = '0;
    n = inst == 0 ? obs_a.size() : obs_b.size();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (start + i >= n) begin
        bad = i;
        act = '0;
        break;
      end
      act = inst == 0 ? obs_a[start+i] : obs_b[start+i];
      if (act != exp_q[i]) begin
        bad = i;
        break;
      end
    end
    checks++;
    if (bad < 0) passes++;
    else $display("FAIL %s: byte %0d got %h expected %h", nm, bad, act, exp_q[bad]);
  endtask

  task automatic write_a(input logic [23:0] dg, input int dp);
    @(negedge clk);
    a_dig = dg;
    a_dp = 3'(dp);
    a_wr = 1'b1;
    @(negedge clk);
    a_wr = 1'b0;
  endtask

  task automatic write_b(input logic [11:0] dg, input int dp);
    @(negedge clk);
    b_dig = dg;
    b_dp = 2'(dp);
    b_wr = 1'b1;
    @(negedge clk);
    b_wr = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int inst, input int target);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 30000; i++) begin
      @(negedge clk);
      if (inst == 0 ? (a_syncs >= target && !a_busy) : (b_syncs >= target && !b_busy)) begin
        ok = 1'b1;
        break;
      end
    end
    chk({nm, " frame done"}, ok, 1);
  endtask

  task automatic wait_bytes_a(input string nm, input int n);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 30000; i++) begin
      @(negedge clk);
      if (obs_a.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    chk({nm, " bytes reached"}, ok, 1);
  endtask

  typedef struct {
    logic [23:0] dg;
    int dp;
    int exp_len;
    logic [3:0] exp_first;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int start, base, n, dpcnt, zcnt;
    logic ok;
    logic [23:0] rd;
    vecs[0] = '{24'h123456, 6, 504, 4'h6};
    vecs[1] = '{24'h000120, 3, 504, 4'h0};
    vecs[2] = '{24'h000000, 6, 504, 4'h0};
    vecs[3] = '{24'h987654, 0, 504, 4'h4};
    vecs[4] = '{24'h000009, 7, 504, 4'h9};
    vecs[5] = '{24'h100000, 5, 504, 4'h0};
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset busy", a_busy, 0);
    chk("reset ready", a_ready, 1);
    chk("reset write_stb", a_stb, 0);
    chk("reset sync_stb", a_sync, 0);
    chk("reset b busy", b_busy, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      start = obs_a.size();
      base = a_syncs;
      write_a(vecs[v].dg, vecs[v].dp);
      wait_done("vec", 0, base + 1);
      chk("vec length", obs_a.size() - start, vecs[v].exp_len);
      chk("vec sync count", a_syncs - base, 1);
      if (obs_a.size() > start) chk("vec first digit", obs_a[start][27:24], vecs[v].exp_first);
      check_frame("vec frame", 0, start, vecs[v].dg, vecs[v].dp);
      if (v == 0 && obs_a.size() >= start + 5) begin
        chk("first x", obs_a[start][23:16], 0);
        chk("first y", obs_a[start][15:8], 0);
        chk("byte3 y", obs_a[start+3][15:8], 3);
        chk("byte3 x", obs_a[start+3][23:16], 0);
        chk("byte4 y wrap", obs_a[start+4][15:8], 0);
        chk("byte4 x step", obs_a[start+4][23:16], 1);
      end
      if (v == 1 && obs_a.size() >= start + 504) begin
        dpcnt = 0;
        zcnt = 0;
        for (int i = 0; i < 504; i++) begin
          if (obs_a[start+i][28] && i >= 252 && i < 336) dpcnt++;
          else if (obs_a[start+i][28]) dpcnt += 1000;
          if (i >= 336 && obs_a[start+i][7:0] == 8'h00) zcnt++;
        end
        chk("dp only on digit 3", dpcnt, 84);
`ifdef DIGIT_STREAMER_BLANK_EN
        chk("digits 4,5 blanked", zcnt, 168);
`else
        chk("digits 4,5 shown", zcnt, 0);
`endif
      end
    end

    // Gap columns and MSD-first order on the 3-digit instance.
    start = obs_b.size();
    base = b_syncs;
    write_b(12'h987, 3);
    wait_done("gap", 1, base + 1);
    chk("gap length", obs_b.size() - start, 268);
    check_frame("gap frame", 1, start, 24'h987, 3);
    if (obs_b.size() >= start + 268) begin
      zcnt = 0;
      for (int i = 84; i < 92; i++) if (obs_b[start+i][7:0] == 8'h00) zcnt++;
      chk("gap bytes zero", zcnt, 8);
      chk("byte before gap", obs_b[start+83][7:0], 8'hFF);
      chk("byte after gap", obs_b[start+92][7:0], 8'hFF);
      chk("last byte x", obs_b[start+267][23:16], 20);
    end
    start = obs_b.size();
    base = b_syncs;
    write_b(12'h009, 3);
    wait_done("msd", 1, base + 1);
    check_frame("msd frame", 1, start, 24'h009, 3);
    if (obs_b.size() >= start + 268) begin
      chk("msd slot0 digit", obs_b[start][27:24], 0);
      chk("msd slot1 digit", obs_b[start+92][27:24], 0);
      chk("msd slot2 digit", obs_b[start+184][27:24], 9);
    end

    // Pending buffer: second write queued, third dropped.
    start = obs_a.size();
    base = a_syncs;
    write_a(24'h123456, 6);
    wait_bytes_a("pend", start + 50);
    write_a(24'h111111, 6);
    chk("ready low after pending write", a_ready, 0);
    write_a(24'h222222, 6);
    chk("ready still low", a_ready, 0);
    ok = 1'b0;
    for (int i = 0; i < 30000; i++) begin
      @(negedge clk);
      if (a_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("ready returns", ok, 1);
    chk("ready with second frame", a_busy, 1);
    chk("first frame synced at ready", a_syncs - base, 1);
    wait_done("pend", 0, base + 2);
    repeat (50) @(negedge clk);
    chk("pend no third frame busy", a_busy, 0);
    chk("pend total length", obs_a.size() - start, 1008);
    chk("pend sync count", a_syncs - base, 2);
    check_frame("pend frame1", 0, start, 24'h123456, 6);
    check_frame("pend frame2", 0, start + 504, 24'h111111, 6);

    // Reset mid-frame with a pending value queued.
    start = obs_a.size();
    base = a_syncs;
    write_a(24'h654321, 2);
    write_a(24'h333333, 6);
    wait_bytes_a("rst", start + 100);
    #2 rst_n = 1'b0;
    #1;
    chk("rst busy", a_busy, 0);
    chk("rst write_stb", a_stb, 0);
    chk("rst sync_stb", a_sync, 0);
    chk("rst ready", a_ready, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst no sync", a_syncs - base, 0);
    chk("rst pending dropped", a_busy, 0);
    start = obs_a.size();
    write_a(24'h123456, 6);
    wait_done("post rst", 0, base + 1);
    chk("post rst length", obs_a.size() - start, 504);
    check_frame("post rst frame", 0, start, 24'h123456, 6);

    // Randomised values and driver latency.
    hold_lo = 1;
    hold_hi = 3;
    for (int r = 0; r < 4; r++) begin
      n = int'($urandom_range(6, 0));
      rd = '0;
      for (int k = 0; k < 6; k++) if (k < 6 - n) rd[4*k +: 4] = 4'($urandom_range(9, 0));
      start = obs_a.size();
      base = a_syncs;
      n = int'($urandom_range(7, 0));
      write_a(rd, n);
      wait_done("rand a", 0, base + 1);
      chk("rand a length", obs_a.size() - start, 504);
      check_frame("rand a frame", 0, start, rd, n);
    end
    for (int r = 0; r < 3; r++) begin
      rd = '0;
      for (int k = 0; k < 3; k++) if ($urandom_range(1, 0) == 1) rd[4*k +: 4] = 4'($urandom_range(9, 0));
      start = obs_b.size();
      base = b_syncs;
      n = int'($urandom_range(3, 0));
      write_b(rd[11:0], n);
      wait_done("rand b", 1, base + 1);
      chk("rand b length", obs_b.size() - start, 268);
      check_frame("rand b frame", 1, start, rd, n);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
